coefficient_loader: RTL and testbench



---
 rtl/coeff_loader_pkg.sv | 20 ++
 rtl/flex_counter.sv | 62 ++++++
 rtl/coefficient_loader.sv | 158 +++++++++++++++
 tb/tb_coefficient_loader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coeff_loader_pkg.sv
// Shared types and default sizing for the coefficient loader.
//   loader_state_t : sequencing states of the loader FSM
//   *_DEF          : default parameter values used by the top module
//   WAIT_CNT_BITS  : width of the modwait timeout counter
package coeff_loader_pkg;

  localparam int NUM_COEFFS_DEF = 4;
  localparam int IDX_WIDTH_DEF  = 2;
  localparam int MAX_WAIT_DEF   = 255;
  localparam int WAIT_CNT_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } loader_state_t;

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter with programmable rollover value.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : synchronous clear of count and flag (has priority)
//   count_enable  : advance the count by one this cycle
//   rollover_val  : count value after which the counter wraps to 1
//   count_out     : registered count
//   rollover_flag : registered, high while count_out equals rollover_val
module flex_counter #(
  parameter int NUM_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  logic [NUM_CNT_BITS-1:0] count_r;
  logic [NUM_CNT_BITS-1:0] count_next_s;
  logic                    flag_r;
  logic                    flag_next_s;

  // Next count: clear wins, otherwise count up and wrap after rollover_val.
  always_comb begin
    count_next_s = count_r;
    flag_next_s  = 1'b0;
    if (clear) begin
      count_next_s = CNT_ZERO;
      flag_next_s  = 1'b0;
    end else if (count_enable) begin
      if (count_r == rollover_val) begin
        count_next_s = CNT_ONE;
      end else begin
        count_next_s = count_r + CNT_ONE;
      end
      flag_next_s = (count_next_s == rollover_val);
    end else begin
      count_next_s = count_r;
      flag_next_s  = (count_r == rollover_val);
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= CNT_ZERO;
      flag_r  <= 1'b0;
    end else begin
      count_r <= count_next_s;
      flag_r  <= flag_next_s;
    end
  end

  assign count_out     = count_r;
  assign rollover_flag = flag_r;

endmodule

// File: rtl/coefficient_loader.sv
// Sequences loading of NUM_COEFFS filter coefficients (F0 first) into the FIR
// filter once software confirms a new coefficient set.
//   clk, rst            : clock, asynchronous active-high reset
//   new_coefficient_set : level request from the slave's confirmation flag
//   modwait             : filter busy; a sequence never starts while it is high
//   coefficient_num     : index being loaded (0 when idle / done)
//   load_coeff          : one-cycle pulse, filter latches the indexed coefficient
//   clear_new_coeff     : one-cycle pulse, slave clears its confirmation flag
//   loader_busy         : high in every state except IDLE
//   load_err            : sticky modwait timeout, cleared on next sequence start
// All outputs are registered and change together with the state register.
module coefficient_loader
  import coeff_loader_pkg::*;
#(
  parameter int NUM_COEFFS = NUM_COEFFS_DEF,
  parameter int IDX_WIDTH  = IDX_WIDTH_DEF,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 new_coefficient_set,
  input  logic                 modwait,
  output logic [IDX_WIDTH-1:0] coefficient_num,
  output logic                 load_coeff,
  output logic                 clear_new_coeff,
  output logic                 loader_busy,
  output logic                 load_err
);

  localparam logic [IDX_WIDTH-1:0]     IDX_ZERO   = '0;
  localparam logic [IDX_WIDTH-1:0]     IDX_ONE    = {{(IDX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDX_WIDTH-1:0]     LAST_IDX   = IDX_WIDTH'(NUM_COEFFS - 1);
  localparam logic [WAIT_CNT_BITS-1:0] WAIT_LIMIT = WAIT_CNT_BITS'(MAX_WAIT);

  loader_state_t            state_r;
  logic [IDX_WIDTH-1:0]     index_r;
  logic [IDX_WIDTH-1:0]     num_r;
  logic                     load_r;
  logic                     clear_r;
  logic                     busy_r;
  logic                     err_r;

  logic                     wait_clr_s;
  logic                     wait_en_s;
  logic [WAIT_CNT_BITS-1:0] wait_cnt_s;
  logic                     wait_flag_s;
  logic                     timeout_s;

  // The counter is zeroed during HOLD so every WAIT visit starts from 0,
  // and it only advances on WAIT cycles in which the filter is still busy.
  assign wait_clr_s = (state_r == HOLD);
  assign wait_en_s  = (state_r == WAIT) && modwait;

  flex_counter #(
    .NUM_CNT_BITS (WAIT_CNT_BITS)
  ) u_wait_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear         (wait_clr_s),
    .count_enable  (wait_en_s),
    .rollover_val  (WAIT_LIMIT),
    .count_out     (wait_cnt_s),
    .rollover_flag (wait_flag_s)
  );

  // Timeout once the counter has reached the limit; the flag is qualified
  // by the count it was derived from.
  assign timeout_s = wait_flag_s && (wait_cnt_s == WAIT_LIMIT);

  // Loader FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      index_r <= IDX_ZERO;
      num_r   <= IDX_ZERO;
      load_r  <= 1'b0;
      clear_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      load_r  <= 1'b0;
      clear_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // Never start while the filter is mid-sample.
          if (new_coefficient_set && !modwait) begin
            state_r <= LOAD;
            index_r <= IDX_ZERO;
            num_r   <= IDX_ZERO;
            load_r  <= 1'b1;
            busy_r  <= 1'b1;
            err_r   <= 1'b0;
          end else begin
            state_r <= IDLE;
            num_r   <= IDX_ZERO;
            busy_r  <= 1'b0;
          end
        end
        LOAD: begin
          // modwait from the filter is registered, so it cannot rise yet.
          state_r <= HOLD;
          num_r   <= index_r;
          busy_r  <= 1'b1;
        end
        HOLD: begin
          state_r <= WAIT;
          num_r   <= index_r;
          busy_r  <= 1'b1;
        end
        WAIT: begin
          busy_r <= 1'b1;
          if (timeout_s) begin
            // Remaining coefficients are abandoned.
            state_r <= DONE;
            index_r <= IDX_ZERO;
            num_r   <= IDX_ZERO;
            clear_r <= 1'b1;
            err_r   <= 1'b1;
          end else if (!modwait) begin
            if (index_r == LAST_IDX) begin
              state_r <= DONE;
              index_r <= IDX_ZERO;
              num_r   <= IDX_ZERO;
              clear_r <= 1'b1;
            end else begin
              state_r <= LOAD;
              index_r <= index_r + IDX_ONE;
              num_r   <= index_r + IDX_ONE;
              load_r  <= 1'b1;
            end
          end else begin
            state_r <= WAIT;
            num_r   <= index_r;
          end
        end
        DONE: begin
          state_r <= IDLE;
          index_r <= IDX_ZERO;
          num_r   <= IDX_ZERO;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          index_r <= IDX_ZERO;
          num_r   <= IDX_ZERO;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign coefficient_num = num_r;
  assign load_coeff      = load_r;
  assign clear_new_coeff = clear_r;
  assign loader_busy     = busy_r;
  assign load_err        = err_r;

endmodule

// File: tb/tb_coefficient_loader.sv
// Scoreboard bench for coefficient_loader: stimulus pushes the expected
// load/clear events, a negedge monitor pops and compares them.
module tb_coefficient_loader;

  localparam int NC = 4;
  localparam int IW = 2;
  localparam int MW = 255;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic          new_coefficient_set;
  logic          mw_force;
  logic          mw_auto = 1'b0;
  logic          modwait;
  logic [IW-1:0] coefficient_num;
  logic          load_coeff;
  logic          clear_new_coeff;
  logic          loader_busy;
  logic          load_err;

  assign modwait = mw_force | mw_auto;

  always #5 tb_clk = ~tb_clk;

  coefficient_loader #(
    .NUM_COEFFS (NC),
    .IDX_WIDTH  (IW),
    .MAX_WAIT   (MW)
  ) dut (
    .clk                 (tb_clk),
    .rst                 (rst),
    .new_coefficient_set (new_coefficient_set),
    .modwait             (modwait),
    .coefficient_num     (coefficient_num),
    .load_coeff          (load_coeff),
    .clear_new_coeff     (clear_new_coeff),
    .loader_busy         (loader_busy),
    .load_err            (load_err)
  );

  typedef struct packed {
    logic       is_clear;
    logic [7:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Filter model controls: modwait pulse length range and the index at
  // which modwait is held high until released.
  int mw_lo = 0;
  int mw_hi = 0;
  int stick_idx = -1;
  int last_run = 0;
  int run_len = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: one sequence loads F0 upward; a timeout at stop_idx
  // abandons the rest and ends with the error flag set.
  task automatic push_seq(input int stop_idx);
    ev_t e;
    for (int i = 0; i < NC; i++) begin
      e.is_clear = 1'b0;
      e.val = 8'(i);
      exp_q.push_back(e);
      if (i == stop_idx) break;
    end
    e.is_clear = 1'b1;
    e.val = (stop_idx >= 0) ? 8'd1 : 8'd0;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for a load (which=0) or clear (which=1) pulse at a negedge.
  task automatic wait_evt(input int which, input int budget, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge tb_clk);
      n++;
      hit = (which == 0) ? load_coeff : clear_new_coeff;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_bound: which=%0d got none expected pulse within %0d", which, budget);
      n = -1;
    end
  endtask

  // Slave behaviour: flag drops on the edge where clear_new_coeff is seen.
  task automatic finish_seq(input int budget);
    int n;
    wait_evt(1, budget, n);
    @(posedge tb_clk);
    #1 new_coefficient_set = 1'b0;
  endtask

  // Filter model: modwait rises the cycle after each load_coeff.
  int drv_idx;
  int drv_len;
  always @(posedge tb_clk) begin
    if (mw_hi > 0 && load_coeff && !rst) begin
      drv_idx = int'(coefficient_num);
      drv_len = $urandom_range(mw_hi, mw_lo);
      #1 mw_auto = 1'b1;
      if (drv_idx == stick_idx) begin
        while (drv_idx == stick_idx) @(posedge tb_clk);
      end else begin
        repeat (drv_len) @(posedge tb_clk);
      end
      #1 mw_auto = 1'b0;
    end
  end

  // Monitor: compare every output pulse against the scoreboard head.
  ev_t mon_e;
  always @(negedge tb_clk) begin
    if (!rst) begin
      if (!loader_busy) check("idle_index", int'(coefficient_num), 0);
      if (load_coeff || clear_new_coeff) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: load=%0d clear=%0d num=%0d expected none",
                   load_coeff, clear_new_coeff, coefficient_num);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_clear) begin
            check("clear_pulse", int'(clear_new_coeff), 1);
            check("clear_load_err", int'(load_err), int'(mon_e.val));
          end else begin
            check("load_pulse", int'(load_coeff), 1);
            check("load_index", int'(coefficient_num), int'(mon_e.val));
            check("load_err_in_seq", int'(load_err), 0);
          end
        end
      end
    end
  end

  // Length of the most recent loader_busy high run.
  always @(negedge tb_clk) begin
    if (rst) begin
      run_len = 0;
    end else if (loader_busy) begin
      run_len = run_len + 1;
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int defer;
    rst = 1'b1;
    new_coefficient_set = 1'b1;
    mw_force = 1'b1;

    // Reset with request and busy filter present.
    repeat (2) @(posedge tb_clk);
    #1;
    check("rst_num", int'(coefficient_num), 0);
    check("rst_load", int'(load_coeff), 0);
    check("rst_clear", int'(clear_new_coeff), 0);
    check("rst_busy", int'(loader_busy), 0);
    check("rst_err", int'(load_err), 0);
    rst = 1'b0;

    // Deferral: request pending while the filter is busy.
    defer = $urandom_range(8, 5);
    for (int i = 0; i < defer; i++) begin
      @(negedge tb_clk);
      check("defer_busy", int'(loader_busy), 0);
      check("defer_load", int'(load_coeff), 0);
    end
    @(posedge tb_clk);
    push_seq(-1);
    #1 mw_force = 1'b0;
    wait_evt(0, 10, n);
    check("defer_latency", n, 2);
    finish_seq(60);
    repeat (2) @(negedge tb_clk);
    check("busy_cycles", last_run, NC * 3 + 1);

    // Nominal: fixed 2-cycle modwait, then randomized pulse lengths.
    for (int s = 0; s < 7; s++) begin
      mw_lo = (s == 0) ? 2 : 1;
      mw_hi = (s == 0) ? 2 : 6;
      repeat ($urandom_range(5, 1)) @(posedge tb_clk);
      #1;
      push_seq(-1);
      new_coefficient_set = 1'b1;
      if ($urandom_range(1, 0) == 1) begin
        wait_evt(0, 10, n);
        @(posedge tb_clk);
        #1 new_coefficient_set = 1'b0;
      end
      finish_seq(100);
    end
    repeat (3) @(negedge tb_clk);
    check("nominal_drain", exp_q.size(), 0);

    // Timeout: filter never finishes coefficient 1.
    mw_lo = 2;
    mw_hi = 2;
    stick_idx = 1;
    @(posedge tb_clk);
    #1;
    push_seq(1);
    new_coefficient_set = 1'b1;
    wait_evt(0, 10, n);
    wait_evt(0, 20, n);
    wait_evt(1, 400, n);
    check("timeout_latency", n, 2 + MW + 1);
    @(posedge tb_clk);
    #1 new_coefficient_set = 1'b0;
    stick_idx = -1;
    repeat (4) @(negedge tb_clk);
    check("err_sticky", int'(load_err), 1);
    check("err_idle_busy", int'(loader_busy), 0);
    @(posedge tb_clk);
    #1;
    push_seq(-1);
    new_coefficient_set = 1'b1;
    wait_evt(0, 10, n);
    check("err_cleared", int'(load_err), 0);
    finish_seq(100);

    // Reset while waiting on coefficient 2.
    stick_idx = 2;
    repeat (2) @(posedge tb_clk);
    #1;
    push_seq(-1);
    new_coefficient_set = 1'b1;
    for (int i = 0; i < 3; i++) wait_evt(0, 30, n);
    repeat (10) @(posedge tb_clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_num", int'(coefficient_num), 0);
    check("midrst_load", int'(load_coeff), 0);
    check("midrst_clear", int'(clear_new_coeff), 0);
    check("midrst_busy", int'(loader_busy), 0);
    check("midrst_err", int'(load_err), 0);
    check("midrst_pending", exp_q.size(), 2);
    exp_q.delete();
    stick_idx = -1;
    repeat (3) @(posedge tb_clk);
    #1;
    push_seq(-1);
    rst = 1'b0;
    finish_seq(100);

    // Back-to-back: flag held until the slave clears it; no second run.
    mw_lo = 1;
    mw_hi = 3;
    repeat (2) @(posedge tb_clk);
    #1;
    push_seq(-1);
    new_coefficient_set = 1'b1;
    finish_seq(100);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge tb_clk);
      if (load_coeff) n++;
    end
    check("b2b_no_restart", n, 0);
    check("final_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
